// File: rtl/fp_issue_wb_scheduler_pkg.sv
// Shared FP writeback types and the fflags merge helper used by the FPU
// dispatch/writeback scheduler.
package fp_issue_wb_scheduler_pkg;

  localparam int FP_MAX_UNITS = 8;
  localparam int FP_FLAGS_W   = 5;
  localparam int FP_FLEN_MAX  = 64;
  localparam int FP_ID_W_MAX  = 8;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef struct packed {
    logic [FP_ID_W_MAX-1:0] id;
    logic [FP_FLEN_MAX-1:0] data;
    fflags_t                fflags;
  } fp_wb_result_t;

  // Flags reach the CSR unit only for writebacks that are actually accepted.
  function automatic fflags_t merge_fflags(input logic    fp_acc,
                                           input fflags_t fp_f,
                                           input logic    int_acc,
                                           input fflags_t int_f);
    fflags_t m;
    m = '0;
    if (fp_acc)  m = fp_f;
    if (int_acc) m = m | int_f;
    return m;
  endfunction

endpackage

// File: rtl/fp_issue_wb_scheduler_arb.sv
// Round-robin arbiter: grants the first request at or after the pointer and
// advances the pointer past the winner only when the grant is consumed.
module fp_rr_arbiter
  import fp_issue_wb_scheduler_pkg::*;
#(
  parameter  int NUM_REQ = 5,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic               any
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt_idx;

  always_comb begin
    int k;
    k       = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!any && req[k]) begin
        any     = 1'b1;
        gnt_idx = IDX_W'(k);
      end
    end
    if (en && any) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && any) begin
      ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fp_issue_wb_scheduler.sv
// FPU dispatch and writeback scheduler: credit-limited issue routing to N
// sub-units and round-robin result collection into one writeback register.
module fp_issue_wb_scheduler
  import fp_issue_wb_scheduler_pkg::*;
#(
  parameter int NUM_UNITS    = 5,
  parameter int ID_W         = 3,
  parameter int FLEN         = 64,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_new_request,
  input  logic [NUM_UNITS-1:0]      issue_unit,
  input  logic [ID_W-1:0]           issue_id,
  output logic                      issue_ready,
  output logic [NUM_UNITS-1:0]      unit_new_request,
  output logic [ID_W-1:0]           unit_id,
  input  logic [NUM_UNITS-1:0]      unit_ready,
  input  logic [NUM_UNITS-1:0]      res_done,
  input  logic [NUM_UNITS*ID_W-1:0] res_id,
  input  logic [NUM_UNITS*FLEN-1:0] res_data,
  input  logic [NUM_UNITS*5-1:0]    res_fflags,
  output logic [NUM_UNITS-1:0]      res_ack,
  output logic                      wb_done,
  output logic [ID_W-1:0]           wb_id,
  output logic [FLEN-1:0]           wb_rd,
  input  logic                      wb_ack,
  input  logic                      int_accepted,
  input  logic [4:0]                int_fflags,
  output logic [4:0]                fflags
);

  localparam int                CNT_W   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0]       cnt [NUM_UNITS];
  logic                   ld;
  logic                   any_res;
  logic [NUM_UNITS-1:0]   gnt;
  logic [ID_W-1:0]        sel_id;
  logic [FLEN-1:0]        sel_data;
  fflags_t                sel_flags;
  fflags_t                wb_flags_p1;
  logic                   fp_acc;

  // Issue and ack in the same cycle cancel; limits are enforced upstream by issue_ready.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                input logic             inc,
                                                input logic             dec);
    logic [CNT_W-1:0] n;
    n = c;
    if (inc && !dec && (c != CNT_MAX)) n = c + 1'b1;
    if (dec && !inc && (c != '0))      n = c - 1'b1;
    return n;
  endfunction

  always_comb begin
    issue_ready = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      issue_ready = issue_ready | (issue_unit[i] & unit_ready[i] & (cnt[i] != CNT_MAX));
    end
  end

  assign unit_new_request = issue_unit & {NUM_UNITS{issue_new_request & issue_ready}};
  assign unit_id          = issue_id;

  // A held, unconsumed result blocks new grants; an accepted one is replaced in the same edge.
  assign ld = ~wb_done | wb_ack;

  fp_rr_arbiter #(
    .NUM_REQ (NUM_UNITS)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req (res_done),
    .en  (ld),
    .gnt (gnt),
    .any (any_res)
  );

  assign res_ack = gnt;

  always_comb begin
    sel_id    = '0;
    sel_data  = '0;
    sel_flags = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      sel_id    = sel_id    | (res_id[i*ID_W +: ID_W]   & {ID_W{gnt[i]}});
      sel_data  = sel_data  | (res_data[i*FLEN +: FLEN] & {FLEN{gnt[i]}});
      sel_flags = sel_flags | (res_fflags[i*5 +: 5]     & {5{gnt[i]}});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_UNITS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        cnt[i] <= cnt_step(cnt[i], unit_new_request[i], res_ack[i]);
      end
    end
  end

  // Stage p1: single-entry writeback output register
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_done     <= 1'b0;
      wb_id       <= '0;
      wb_rd       <= '0;
      wb_flags_p1 <= '0;
    end else if (ld) begin
      wb_done <= any_res;
      if (any_res) begin
        wb_id       <= sel_id;
        wb_rd       <= sel_data;
        wb_flags_p1 <= sel_flags;
      end
    end
  end

  assign fp_acc = wb_done & wb_ack;
  assign fflags = merge_fflags(fp_acc, wb_flags_p1, int_accepted, fflags_t'(int_fflags));

endmodule

// File: tb/tb_fp_issue_wb_scheduler.sv
// Directed bench for the FP issue/writeback scheduler with a writeback scoreboard.
module tb_fp_issue_wb_scheduler;

  localparam int NU  = 5;
  localparam int IDW = 3;
  localparam int FL  = 64;
  localparam int MI  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_new_request;
  logic [NU-1:0]     issue_unit;
  logic [IDW-1:0]    issue_id;
  logic              issue_ready;
  logic [NU-1:0]     unit_new_request;
  logic [IDW-1:0]    unit_id;
  logic [NU-1:0]     unit_ready;
  logic [NU-1:0]     res_done;
  logic [NU*IDW-1:0] res_id;
  logic [NU*FL-1:0]  res_data;
  logic [NU*5-1:0]   res_fflags;
  logic [NU-1:0]     res_ack;
  logic              wb_done;
  logic [IDW-1:0]    wb_id;
  logic [FL-1:0]     wb_rd;
  logic              wb_ack;
  logic              int_accepted;
  logic [4:0]        int_fflags;
  logic [4:0]        fflags;

  typedef struct {
    logic [IDW-1:0] id;
    logic [FL-1:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_issue_wb_scheduler #(
    .NUM_UNITS    (NU),
    .ID_W         (IDW),
    .FLEN         (FL),
    .MAX_INFLIGHT (MI)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .issue_new_request (issue_new_request),
    .issue_unit        (issue_unit),
    .issue_id          (issue_id),
    .issue_ready       (issue_ready),
    .unit_new_request  (unit_new_request),
    .unit_id           (unit_id),
    .unit_ready        (unit_ready),
    .res_done          (res_done),
    .res_id            (res_id),
    .res_data          (res_data),
    .res_fflags        (res_fflags),
    .res_ack           (res_ack),
    .wb_done           (wb_done),
    .wb_id             (wb_id),
    .wb_rd             (wb_rd),
    .wb_ack            (wb_ack),
    .int_accepted      (int_accepted),
    .int_fflags        (int_fflags),
    .fflags            (fflags)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input int u, input logic [IDW-1:0] id, input logic [FL-1:0] d,
                         input logic [4:0] f);
    res_id[u*IDW +: IDW] = id;
    res_data[u*FL +: FL] = d;
    res_fflags[u*5 +: 5] = f;
  endtask

  task automatic push_exp(input logic [IDW-1:0] id, input logic [FL-1:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic issue(input int u, input logic [IDW-1:0] id);
    logic [NU-1:0] oh;
    oh                = NU'(1) << u;
    issue_new_request = 1'b1;
    issue_unit        = oh;
    issue_id          = id;
    #1;
    check("issue_ready", 64'(issue_ready), 64'd1);
    check("unit_new_request", 64'(unit_new_request), 64'(oh));
    check("unit_id", 64'(unit_id), 64'(id));
    tick();
    issue_new_request = 1'b0;
  endtask

  // Writeback scoreboard: every accepted result must match the next expected one.
  always @(negedge clk) begin
    if (!rst && wb_done && wb_ack) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got id %0h data %0h, expected nothing", wb_id, wb_rd);
      end else begin
        e = exp_q.pop_front();
        check("wb_id", 64'(wb_id), 64'(e.id));
        check("wb_rd", wb_rd, e.data);
      end
    end
  end

  // Illegal-use and credit-bound monitors.
  always @(negedge clk) begin
    if (!rst) begin
      if (issue_new_request && !$onehot(issue_unit)) begin
        checks++;
        errors++;
        $display("FAIL issue_onehot: got %b, expected one-hot", issue_unit);
      end
      for (int i = 0; i < NU; i++) begin
        if (res_done[i] && dut.cnt[i] == 0) begin
          checks++;
          errors++;
          $display("FAIL res_done_no_credit unit %0d: got cnt 0, expected nonzero", i);
        end
        if (int'(dut.cnt[i]) > MI) begin
          checks++;
          errors++;
          $display("FAIL cnt_overflow unit %0d: got %0d, limit %0d", i, dut.cnt[i], MI);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int            rem [NU];
    int            seq [5];
    logic [NU-1:0] oh;

    rst = 1'b1; issue_new_request = 1'b0; issue_unit = '0; issue_id = '0;
    unit_ready = '1; res_done = '0; res_id = '0; res_data = '0; res_fflags = '0;
    wb_ack = 1'b0; int_accepted = 1'b0; int_fflags = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_wb_done", 64'(wb_done), 64'd0);
    check("rst_wb_id", 64'(wb_id), 64'd0);
    check("rst_wb_rd", wb_rd, 64'd0);
    check("rst_res_ack", 64'(res_ack), 64'd0);
    check("rst_unit_new_request", 64'(unit_new_request), 64'd0);
    check("rst_ptr", 64'(dut.u_arb.ptr), 64'd0);
    for (int i = 0; i < NU; i++) check("rst_cnt", 64'(dut.cnt[i]), 64'd0);

    // Credits for the fairness run, then the limit on unit 0
    issue(0, 3'd1); issue(0, 3'd2); issue(2, 3'd3); issue(2, 3'd4); issue(4, 3'd5);
    issue_new_request = 1'b1; issue_unit = 5'b00001;
    #1;
    check("credit_full_ready", 64'(issue_ready), 64'd0);
    check("credit_full_fwd", 64'(unit_new_request), 64'd0);
    issue_new_request = 1'b0;
    check("fill_cnt0", 64'(dut.cnt[0]), 64'd2);
    check("fill_cnt2", 64'(dut.cnt[2]), 64'd2);
    check("fill_cnt4", 64'(dut.cnt[4]), 64'd1);

    // Fairness with wb_ack held high
    rem = '{2, 0, 2, 0, 1};
    seq = '{0, 2, 4, 0, 2};
    wb_ack = 1'b1;
    for (int u = 0; u < NU; u++) set_res(u, IDW'(u), 64'h100 + 64'(u), 5'b0);
    for (int k = 0; k < 5; k++) begin
      for (int u = 0; u < NU; u++) res_done[u] = (rem[u] > 0);
      #1;
      oh = NU'(1) << seq[k];
      check("fair_grant", 64'(res_ack), 64'(oh));
      push_exp(IDW'(seq[k]), 64'h100 + 64'(seq[k]));
      rem[seq[k]]--;
      tick();
      check("fair_no_bubble", 64'(wb_done), 64'd1);
    end
    res_done = '0;
    tick();
    check("fair_drain", 64'(wb_done), 64'd0);
    check("fair_ptr", 64'(dut.u_arb.ptr), 64'd3);

    // Credit release on unit 1
    issue(1, 3'd1); issue(1, 3'd2);
    issue_new_request = 1'b1; issue_unit = 5'b00010; issue_id = 3'd3;
    res_done = 5'b00010; set_res(1, 3'd5, 64'h5555, 5'b0);
    #1;
    check("credit_u1_ready", 64'(issue_ready), 64'd0);
    check("credit_u1_fwd", 64'(unit_new_request), 64'd0);
    check("credit_u1_ack", 64'(res_ack), 64'b00010);
    push_exp(3'd5, 64'h5555);
    tick();
    res_done = '0;
    #1;
    check("credit_release_ready", 64'(issue_ready), 64'd1);
    check("credit_release_fwd", 64'(unit_new_request), 64'b00010);
    check("credit_release_cnt", 64'(dut.cnt[1]), 64'd1);
    tick();
    issue_new_request = 1'b0;
    check("credit_refill_cnt", 64'(dut.cnt[1]), 64'd2);

    // Issue and ack on unit 0 in the same cycle
    issue(0, 3'd4);
    issue_new_request = 1'b1; issue_unit = 5'b00001; issue_id = 3'd5;
    res_done = 5'b00001; set_res(0, 3'd6, 64'h6666, 5'b0);
    #1;
    check("simul_ready", 64'(issue_ready), 64'd1);
    check("simul_fwd", 64'(unit_new_request), 64'b00001);
    check("simul_ack", 64'(res_ack), 64'b00001);
    push_exp(3'd6, 64'h6666);
    tick();
    issue_new_request = 1'b0; res_done = '0;
    check("simul_cnt", 64'(dut.cnt[0]), 64'd1);

    // Backpressure, then flag merging
    issue(0, 3'd6);
    wb_ack = 1'b0;
    set_res(0, 3'd3, 64'h3FF0_0000_0000_0000, 5'b00001);
    res_done = 5'b00001;
    #1;
    check("bp_load_ack", 64'(res_ack), 64'b00001);
    push_exp(3'd3, 64'h3FF0_0000_0000_0000);
    tick();
    set_res(0, 3'd4, 64'h4444, 5'b00010);
    for (int k = 0; k < 4; k++) begin
      int_accepted = (k == 2);
      int_fflags   = (k == 2) ? 5'b00100 : 5'b0;
      #1;
      check("bp_wb_done", 64'(wb_done), 64'd1);
      check("bp_wb_id", 64'(wb_id), 64'd3);
      check("bp_wb_rd", wb_rd, 64'h3FF0_0000_0000_0000);
      check("bp_res_ack", 64'(res_ack), 64'd0);
      if (k == 2) check("flags_int_only", 64'(fflags), 64'b00100);
      tick();
    end
    wb_ack = 1'b1; int_accepted = 1'b1; int_fflags = 5'b10000;
    #1;
    check("flags_merge", 64'(fflags), 64'b10001);
    check("bp_release_ack", 64'(res_ack), 64'b00001);
    push_exp(3'd4, 64'h4444);
    tick();
    res_done = '0; int_accepted = 1'b0; int_fflags = '0; wb_ack = 1'b0;
    #1;
    check("flags_idle", 64'(fflags), 64'd0);
    wb_ack = 1'b1;
    #1;
    check("flags_fp_only", 64'(fflags), 64'b00010);
    tick();
    check("bp_drain", 64'(wb_done), 64'd0);
    check("bp_cnt0", 64'(dut.cnt[0]), 64'd0);

    // Reset while a result is held and credits are outstanding
    issue(2, 3'd7);
    wb_ack = 1'b0;
    res_done = 5'b00010; set_res(1, 3'd7, 64'h7777, 5'b0);
    #1;
    check("mid_ack", 64'(res_ack), 64'b00010);
    tick();
    res_done = '0;
    #1;
    check("mid_wb_done", 64'(wb_done), 64'd1);
    check("mid_wb_id", 64'(wb_id), 64'd7);
    check("mid_cnt1", 64'(dut.cnt[1]), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_wb_done", 64'(wb_done), 64'd0);
    check("mid_rst_wb_id", 64'(wb_id), 64'd0);
    check("mid_rst_wb_rd", wb_rd, 64'd0);
    check("mid_rst_ptr", 64'(dut.u_arb.ptr), 64'd0);
    for (int i = 0; i < NU; i++) check("mid_rst_cnt", 64'(dut.cnt[i]), 64'd0);

    wb_ack = 1'b1;
    repeat (2) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
